esc_pwm_gen: RTL and testbench
==============================

ESC_PWM_GEN -- requirements
Module: esc_pwm_gen

Interface
REQ-001 Parameter FRAME_CYCLES, default 1000000, SHALL set the frame period in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter MIN_PULSE, default 50000, SHALL set the high time in cycles for command 0 (1.0 ms).
REQ-003 Parameter STEP, default 50, SHALL set the high-time cycles added per command LSB.
REQ-004 Parameter CMD_MAX, default 1000, SHALL set the full-scale command value.
REQ-005 Parameter SLEW_STEP, default 20, SHALL set the maximum per-frame command change when slew limiting is compiled in.
REQ-006 clk  input  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-007 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 cmd  input  13  SHALL carry the throttle command, 0..CMD_MAX, in the same scale the PWM decoder produces.
REQ-009 cmd_valid  input  1  SHALL be a single-cycle strobe qualifying cmd.
REQ-010 arm  input  1  SHALL enable output of the commanded value; when low, the output SHALL be forced to command 0.
REQ-011 pwm_out  output  1  SHALL be the registered servo/ESC PWM output.
REQ-012 frame_start  output  1  SHALL be a one-cycle pulse on the first high cycle of each frame.
REQ-013 active_cmd  output  13  SHALL report the command value used for the current frame.
REQ-014 cmd_clamped  output  1  SHALL be a one-cycle pulse when an accepted cmd exceeded CMD_MAX.

Function
REQ-015 A cmd_valid strobe SHALL write min(cmd, CMD_MAX) into a shadow register, and cmd_clamped SHALL pulse in the following cycle if cmd > CMD_MAX.
REQ-016 The FSM SHALL have three states: IDLE, HIGH and LOW.
REQ-017 IDLE SHALL transition to HIGH on the first clk edge after rst_n deasserts.
REQ-018 HIGH SHALL transition to LOW after pulse_len cycles.
REQ-019 LOW SHALL transition to HIGH after FRAME_CYCLES - pulse_len cycles, so the frame period is exactly FRAME_CYCLES.
REQ-020 On each entry to HIGH, the block SHALL do all of the following:
- load active_cmd: shadow if arm = 1, else 0;
- compute pulse_len = MIN_PULSE + STEP * active_cmd, at 32-bit width, no overflow;
- assert frame_start;
- clear the frame counter.
REQ-021 pwm_out SHALL be 1 exactly in HIGH and 0 in IDLE and LOW; the high time SHALL be pulse_len cycles and SHALL NOT vary within a frame.
REQ-022 If cmd_valid coincides with a frame-start load, the pre-update shadow value SHALL be used; the new value SHALL take effect the next frame.
REQ-023 Changes to cmd or arm mid-frame SHALL NOT alter the current frame; they SHALL apply at the next frame start.
REQ-024 Multiple cmd_valid strobes within one frame SHALL keep only the last value.
REQ-025 The frame counter SHALL be 32 bits; FRAME_CYCLES > MIN_PULSE + STEP*CMD_MAX is a parameter constraint, and the counter SHALL never wrap.

Reset
REQ-026 While rst_n = 0, the block SHALL hold:
- state = IDLE;
- pwm_out = 0, frame_start = 0, cmd_clamped = 0;
- active_cmd = 0, shadow = 0, frame counter = 0.
REQ-027 Reset assertion mid-frame SHALL drive pwm_out low immediately (asynchronously), truncating the pulse.
REQ-028 After reset, the first frame SHALL output the command-0 pulse (MIN_PULSE) unless cmd_valid arrived before the first frame start.

Configuration
REQ-029 With macro ESC_PWM_SLEW_EN defined, the frame-start load SHALL move active_cmd toward its target by at most SLEW_STEP per frame.
- Target: shadow when arm = 1, else 0.
- Disarm SHALL bypass slewing and load 0 at once.
REQ-030 Without ESC_PWM_SLEW_EN, active_cmd SHALL load its target directly; there SHALL be no slew register or comparator logic.

Verification
REQ-031 Reset release, arm = 0, no cmd -> frame_start every 1,000,000 cycles; pwm_out high 50,000 cycles per frame.
REQ-032 arm = 1, cmd = 500 strobed mid-frame -> current frame unchanged; next frame high time 75,000 cycles, active_cmd = 500.
REQ-033 cmd = 1500 strobed -> cmd_clamped pulses once; next frame high time 100,000 cycles, active_cmd = 1000.
REQ-034 cmd_valid on the frame-start cycle with cmd = 200 (shadow previously 100) -> that frame uses 100 (55,000 cycles); the following frame uses 200 (60,000 cycles).
REQ-035 rst_n pulsed low 30,000 cycles into a 75,000-cycle high phase -> pwm_out low within the reset; after release, IDLE then a 50,000-cycle frame.
REQ-036 With ESC_PWM_SLEW_EN, active 0, cmd = 1000, arm = 1 -> active_cmd steps 20, 40, ... reaching 1000 at frame 50; dropping arm -> next frame active_cmd = 0.

Source files
------------

// File: rtl/esc_pwm_gen.sv
// Servo/ESC PWM frame generator: a fixed-period frame whose high time is set by a
// latched throttle command. Optional slew limiting is compiled in with ESC_PWM_SLEW_EN.
module esc_pwm_gen #(
    parameter int unsigned FRAME_CYCLES = 1000000,
    parameter int unsigned MIN_PULSE    = 50000,
    parameter int unsigned STEP         = 50,
    parameter int unsigned CMD_MAX      = 1000,
    parameter int unsigned SLEW_STEP    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] cmd,
    input  logic        cmd_valid,
    input  logic        arm,
    output logic        pwm_out,
    output logic        frame_start,
    output logic [12:0] active_cmd,
    output logic        cmd_clamped
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [12:0] CMD_MAX_W  = 13'(CMD_MAX);
    localparam logic [31:0] FRAME_LAST = 32'(FRAME_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] frame_cnt;
    logic [31:0] pulse_len;
    logic [12:0] shadow;
    logic [12:0] target;
    logic [12:0] next_cmd;
    logic        load;
    logic        over_max;

    assign over_max = (cmd > CMD_MAX_W);
    assign target   = arm ? shadow : 13'd0;

    // The frame counter runs across the whole frame, so the LOW exit at
    // FRAME_LAST gives an exact period whatever the pulse length was.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = HIGH;
                load      = 1'b1;
            end
            HIGH: begin
                if (frame_cnt == pulse_len - 32'd1) state_nxt = LOW;
            end
            LOW: begin
                if (frame_cnt == FRAME_LAST) begin
                    state_nxt = HIGH;
                    load      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ESC_PWM_SLEW_EN
    localparam logic [12:0] SLEW_W = 13'(SLEW_STEP);

    // Disarm drops straight to zero; otherwise step at most SLEW_W toward target.
    always_comb begin
        next_cmd = target;
        if (!arm)
            next_cmd = 13'd0;
        else if (target > active_cmd && (target - active_cmd) > SLEW_W)
            next_cmd = active_cmd + SLEW_W;
        else if (active_cmd > target && (active_cmd - target) > SLEW_W)
            next_cmd = active_cmd - SLEW_W;
    end
`else
    assign next_cmd = target;
`endif

    // NOTE: all state registers use non-blocking assignments so every register
    // samples pre-edge values; this is what makes a cmd_valid on the load edge
    // leave the frame with the old shadow value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            active_cmd  <= 13'd0;
            pulse_len   <= 32'd0;
            frame_cnt   <= 32'd0;
        end else begin
            state       <= state_nxt;
            pwm_out     <= (state_nxt == HIGH);
            frame_start <= load;
            if (load) begin
                active_cmd <= next_cmd;
                pulse_len  <= 32'(MIN_PULSE) + 32'(STEP) * {19'd0, next_cmd};
                frame_cnt  <= 32'd0;
            end else if (state != IDLE) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= 13'd0;
            cmd_clamped <= 1'b0;
        end else begin
            cmd_clamped <= cmd_valid && over_max;
            if (cmd_valid) shadow <= over_max ? CMD_MAX_W : cmd;
        end
    end

endmodule

// File: tb/tb_esc_pwm_gen.sv
// Directed bench for esc_pwm_gen using scaled-down frame parameters; the slew
// sequence replaces the table when ESC_PWM_SLEW_EN is defined.
module tb_esc_pwm_gen;

    localparam int F    = 1200;
    localparam int MINP = 50;
    localparam int STP  = 1;
    localparam int CMAX = 1000;
    localparam int SLEW = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] cmd;
    logic        cmd_valid;
    logic        arm;
    logic        pwm_out;
    logic        frame_start;
    logic [12:0] active_cmd;
    logic        cmd_clamped;

    int n_vec = 0;
    int n_bad = 0;

    esc_pwm_gen #(
        .FRAME_CYCLES(F),
        .MIN_PULSE   (MINP),
        .STEP        (STP),
        .CMD_MAX     (CMAX),
        .SLEW_STEP   (SLEW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .arm        (arm),
        .pwm_out    (pwm_out),
        .frame_start(frame_start),
        .active_cmd (active_cmd),
        .cmd_clamped(cmd_clamped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        arm_v;
        int          nstr;
        logic [12:0] ca;
        logic [12:0] cb;
        int          e_act;
        int          e_clamp;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Starts on the negedge where frame_start is seen; returns on the next one.
    task automatic run_frame(input logic a, input int nstr, input logic [12:0] ca,
                             input logic [12:0] cb, input int at,
                             output int act, output int hi, output int per,
                             output int clamps);
        act    = int'(active_cmd);
        hi     = 0;
        per    = 0;
        clamps = 0;
        while (1) begin
            if (pwm_out) hi++;
            if (cmd_clamped) clamps++;
            cmd_valid = 1'b0;
            if (per == at) begin
                arm = a;
                if (nstr > 0) begin
                    cmd       = ca;
                    cmd_valid = 1'b1;
                end
            end
            if (per == at + 2 && nstr > 1) begin
                cmd       = cb;
                cmd_valid = 1'b1;
            end
            per++;
            @(negedge clk);
            if (frame_start || per > 2 * F) break;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_frame_start(input string name, input int exp_wait);
        int n;
        n = 0;
        while (!frame_start && n <= 4 * F) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp_wait);
    endtask

    task automatic frame_checks(input string tag, input int act, input int hi,
                                input int per, input int e_act);
        check({tag, " active_cmd"}, act, e_act);
        check({tag, " high_time"}, hi, MINP + STP * e_act);
        check({tag, " period"}, per, F);
    endtask

    initial begin
        vec_t tbl[12];
        int act, hi, per, clamps;

        rst_n     = 1'b0;
        cmd       = 13'd0;
        cmd_valid = 1'b0;
        arm       = 1'b0;

        tbl[0]  = '{1'b0, 0, 13'd0,    13'd0,   0,    0};
        tbl[1]  = '{1'b1, 1, 13'd500,  13'd0,   0,    0};
        tbl[2]  = '{1'b1, 0, 13'd0,    13'd0,   500,  0};
        tbl[3]  = '{1'b1, 1, 13'd1500, 13'd0,   500,  1};
        tbl[4]  = '{1'b1, 0, 13'd0,    13'd0,   1000, 0};
        tbl[5]  = '{1'b0, 0, 13'd0,    13'd0,   1000, 0};
        tbl[6]  = '{1'b0, 0, 13'd0,    13'd0,   0,    0};
        tbl[7]  = '{1'b1, 1, 13'd100,  13'd0,   0,    0};
        tbl[8]  = '{1'b1, 2, 13'd300,  13'd250, 100,  0};
        tbl[9]  = '{1'b1, 0, 13'd0,    13'd0,   250,  0};
        tbl[10] = '{1'b1, 1, 13'd1000, 13'd0,   250,  0};
        tbl[11] = '{1'b1, 1, 13'd100,  13'd0,   1000, 0};

        repeat (3) @(negedge clk);
        check("reset pwm_out", int'(pwm_out), 0);
        check("reset frame_start", int'(frame_start), 0);
        check("reset active_cmd", int'(active_cmd), 0);
        check("reset cmd_clamped", int'(cmd_clamped), 0);

        rst_n = 1'b1;
        wait_frame_start("first frame_start latency", 1);

`ifdef ESC_PWM_SLEW_EN
        run_frame(1'b1, 1, 13'd1000, 13'd0, 10, act, hi, per, clamps);
        frame_checks("slew frame 0", act, hi, per, 0);
        for (int k = 1; k <= 50; k++) begin
            run_frame(1'b1, 0, 13'd0, 13'd0, 10, act, hi, per, clamps);
            check($sformatf("slew frame %0d active_cmd", k), act, SLEW * k);
        end
        run_frame(1'b0, 0, 13'd0, 13'd0, 10, act, hi, per, clamps);
        frame_checks("slew disarm frame", act, hi, per, 1000);
        run_frame(1'b0, 0, 13'd0, 13'd0, 10, act, hi, per, clamps);
        frame_checks("slew after disarm", act, hi, per, 0);
`else
        foreach (tbl[i]) begin
            run_frame(tbl[i].arm_v, tbl[i].nstr, tbl[i].ca, tbl[i].cb, 10,
                      act, hi, per, clamps);
            frame_checks($sformatf("v%0d", i), act, hi, per, tbl[i].e_act);
            check($sformatf("v%0d clamp pulses", i), clamps, tbl[i].e_clamp);
        end

        // cmd_valid on the load edge: this frame keeps the old shadow (100)
        run_frame(1'b1, 1, 13'd200, 13'd0, F - 1, act, hi, per, clamps);
        frame_checks("pre-load strobe frame", act, hi, per, 100);
        run_frame(1'b1, 0, 13'd0, 13'd0, 10, act, hi, per, clamps);
        frame_checks("load-edge strobe frame", act, hi, per, 100);

        check("new shadow frame active_cmd", int'(active_cmd), 200);
        repeat (30) @(negedge clk);
        check("pwm high before reset", int'(pwm_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check("pwm async low in reset", int'(pwm_out), 0);
        check("active_cmd cleared in reset", int'(active_cmd), 0);
        repeat (2) @(negedge clk);
        check("frame_start low in reset", int'(frame_start), 0);
        rst_n = 1'b1;
        wait_frame_start("post-reset frame_start latency", 1);
        run_frame(1'b1, 0, 13'd0, 13'd0, 10, act, hi, per, clamps);
        frame_checks("post-reset frame", act, hi, per, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
